// File: rtl/expr_pkg.sv
// rtl/expr_pkg.sv - shared constants, state type and width helper for the expression checker
//
// Purpose : character codes, FSM state enum and the depth-width function
//           used by expr_char_class and expr_stream_checker.
// Ports   : none (package).
package expr_pkg;

   localparam logic [7:0] CH_0      = 8'h30;
   localparam logic [7:0] CH_9      = 8'h39;
   localparam logic [7:0] CH_PLUS   = 8'h2B;
   localparam logic [7:0] CH_MINUS  = 8'h2D;
   localparam logic [7:0] CH_STAR   = 8'h2A;
   localparam logic [7:0] CH_SLASH  = 8'h2F;
   localparam logic [7:0] CH_LPAREN = 8'h28;
   localparam logic [7:0] CH_RPAREN = 8'h29;

   typedef enum logic [1:0] {
      EXPECT      = 2'd0,
      IN_NUM      = 2'd1,
      AFTER_CLOSE = 2'd2,
      ERR         = 2'd3
   } state_t;

   // Bits needed to hold the values 0..max_val inclusive.
   function automatic int depth_w(input int max_val);
      return $clog2(max_val + 1);
   endfunction

endpackage

// File: rtl/expr_char_class.sv
// rtl/expr_char_class.sv - combinational character classifier for the expression checker
//
// Purpose : sorts one ASCII byte into digit / operator / '(' / ')'.
//           Disabled operators and parentheses are reported as none of
//           these, so downstream they fall into the "other byte" error path.
// Ports   : in        [7:0] character under test
//           is_digit        '0'..'9'
//           is_op           '+', '*', '-' (EN_SUB), '/' (EN_DIV)
//           is_lparen       '(' (EN_PAREN)
//           is_rparen       ')' (EN_PAREN)
module expr_char_class
   import expr_pkg::*;
#(
   parameter bit EN_SUB   = 1'b1,
   parameter bit EN_DIV   = 1'b0,
   parameter bit EN_PAREN = 1'b1
) (
   input  logic [7:0] in,
   output logic       is_digit,
   output logic       is_op,
   output logic       is_lparen,
   output logic       is_rparen
);

   always_comb begin
      is_digit  = (in >= CH_0) && (in <= CH_9);
      is_op     = (in == CH_PLUS) || (in == CH_STAR)
                  || (EN_SUB && (in == CH_MINUS))
                  || (EN_DIV && (in == CH_SLASH));
      is_lparen = EN_PAREN && (in == CH_LPAREN);
      is_rparen = EN_PAREN && (in == CH_RPAREN);
   end

endmodule

// File: rtl/expr_stream_checker.sv
// rtl/expr_stream_checker.sv - streaming syntax checker for arithmetic expressions
//
// Purpose : consumes one ASCII character per cycle with in_valid=1 and
//           reports, one cycle later, whether the prefix seen so far is a
//           complete valid expression, already invalid, and its paren depth.
// Ports   : clk                 rising-edge clock
//           clr_n               asynchronous active-low clear
//           restart             synchronous start of a new expression
//           in_valid            in carries a character this cycle
//           in      [7:0]       ASCII character
//           out                 prefix is a complete valid expression
//           err                 sticky: prefix is already invalid
//           depth   [DW-1:0]    currently open parentheses
//           err_pos [POS_W-1:0] 0-based index of the first offending character
module expr_stream_checker
   import expr_pkg::*;
#(
   parameter int MAX_DIGITS = 4,
   parameter int MAX_DEPTH  = 7,
   parameter bit EN_SUB     = 1'b1,
   parameter bit EN_DIV     = 1'b0,
   parameter bit EN_PAREN   = 1'b1,
   parameter int POS_W      = 16
) (
   input  logic                           clk,
   input  logic                           clr_n,
   input  logic                           restart,
   input  logic                           in_valid,
   input  logic [7:0]                     in,
   output logic                           out,
   output logic                           err,
   output logic [depth_w(MAX_DEPTH)-1:0]  depth,
   output logic [POS_W-1:0]               err_pos
);

   localparam int DW = depth_w(MAX_DEPTH);
   localparam int CW = depth_w(MAX_DIGITS);
   localparam logic [DW-1:0] DEPTH_MAX = DW'(MAX_DEPTH);
   localparam logic [CW-1:0] DCNT_MAX  = CW'(MAX_DIGITS);

   logic is_digit, is_op, is_lparen, is_rparen;

   expr_char_class #(
      .EN_SUB   (EN_SUB),
      .EN_DIV   (EN_DIV),
      .EN_PAREN (EN_PAREN)
   ) u_class (
      .in        (in),
      .is_digit  (is_digit),
      .is_op     (is_op),
      .is_lparen (is_lparen),
      .is_rparen (is_rparen)
   );

   state_t             state_q, state_d;
   logic [CW-1:0]      dcnt_q, dcnt_d;
   logic [DW-1:0]      depth_q, depth_d;
   logic               err_q, err_d;
   logic [POS_W-1:0]   err_pos_q, err_pos_d;
   logic [POS_W-1:0]   idx_q, idx_d;
   logic               out_q, out_d;

   // Starting point for this cycle: restart wipes the context so that a
   // character arriving in the same cycle is judged as index 0.
   state_t             b_state;
   logic [CW-1:0]      b_dcnt;
   logic [DW-1:0]      b_depth;
   logic               b_err;
   logic [POS_W-1:0]   b_err_pos;
   logic [POS_W-1:0]   b_idx;
   logic               go_err;

   // State register
   always_ff @(posedge clk or negedge clr_n) begin
      if (!clr_n) begin
         state_q   <= EXPECT;
         dcnt_q    <= '0;
         depth_q   <= '0;
         err_q     <= 1'b0;
         err_pos_q <= '0;
         idx_q     <= '0;
         out_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         dcnt_q    <= dcnt_d;
         depth_q   <= depth_d;
         err_q     <= err_d;
         err_pos_q <= err_pos_d;
         idx_q     <= idx_d;
         out_q     <= out_d;
      end
   end

   // Next-state logic
   always_comb begin
      b_state   = restart ? EXPECT : state_q;
      b_dcnt    = restart ? '0 : dcnt_q;
      b_depth   = restart ? '0 : depth_q;
      b_err     = restart ? 1'b0 : err_q;
      b_err_pos = restart ? '0 : err_pos_q;
      b_idx     = restart ? '0 : idx_q;

      state_d   = b_state;
      dcnt_d    = b_dcnt;
      depth_d   = b_depth;
      err_d     = b_err;
      err_pos_d = b_err_pos;
      idx_d     = b_idx;
      go_err    = 1'b0;

      if (in_valid) begin
         // Index saturates rather than wrapping, so a late error still
         // reports the largest representable position.
         if (b_idx != '1) begin
            idx_d = b_idx + POS_W'(1);
         end

         case (b_state)
            EXPECT: begin
               if (is_digit) begin
                  state_d = IN_NUM;
                  dcnt_d  = CW'(1);
               end else if (is_lparen && (b_depth < DEPTH_MAX)) begin
                  depth_d = b_depth + DW'(1);
               end else begin
                  go_err = 1'b1;
               end
            end
            IN_NUM: begin
               if (is_digit && (b_dcnt < DCNT_MAX)) begin
                  dcnt_d = b_dcnt + CW'(1);
               end else if (is_op) begin
                  state_d = EXPECT;
                  dcnt_d  = '0;
               end else if (is_rparen && (b_depth != '0)) begin
                  state_d = AFTER_CLOSE;
                  dcnt_d  = '0;
                  depth_d = b_depth - DW'(1);
               end else begin
                  go_err = 1'b1;
               end
            end
            AFTER_CLOSE: begin
               if (is_op) begin
                  state_d = EXPECT;
               end else if (is_rparen && (b_depth != '0)) begin
                  depth_d = b_depth - DW'(1);
               end else begin
                  go_err = 1'b1;
               end
            end
            default: begin
               // ERR absorbs everything; depth/dcnt stay frozen.
            end
         endcase

         if (go_err) begin
            state_d   = ERR;
            err_d     = 1'b1;
            err_pos_d = b_idx;
         end
      end
   end

   // Output logic: registered view of whether the next prefix is complete.
   always_comb begin
      out_d = ((state_d == IN_NUM) || (state_d == AFTER_CLOSE)) && (depth_d == '0);
   end

   assign out     = out_q;
   assign err     = err_q;
   assign depth   = depth_q;
   assign err_pos = err_pos_q;

endmodule

// File: tb/tb_expr_stream_checker.sv
// tb/tb_expr_stream_checker.sv - scoreboard bench for expr_stream_checker
module tb_expr_stream_checker;

   logic       clk = 1'b0;
   logic       clr_n = 1'b0;
   logic       restart = 1'b0;
   logic       in_valid = 1'b0;
   logic [7:0] in_ch = 8'h00;

   always #5 clk = ~clk;

   // DUT A: defaults. DUT B: small limits, '/' on, '-' off, 3-bit index.
   // DUT C: defaults with parentheses disabled.
   logic        a_out, a_err;
   logic [2:0]  a_dep;
   logic [15:0] a_pos;
   logic        b_out, b_err;
   logic [1:0]  b_dep;
   logic [2:0]  b_pos;
   logic        c_out, c_err;
   logic [2:0]  c_dep;
   logic [15:0] c_pos;

   expr_stream_checker u_a (
      .clk(clk), .clr_n(clr_n), .restart(restart), .in_valid(in_valid), .in(in_ch),
      .out(a_out), .err(a_err), .depth(a_dep), .err_pos(a_pos)
   );

   expr_stream_checker #(
      .MAX_DIGITS(2), .MAX_DEPTH(3), .EN_SUB(1'b0), .EN_DIV(1'b1), .EN_PAREN(1'b1), .POS_W(3)
   ) u_b (
      .clk(clk), .clr_n(clr_n), .restart(restart), .in_valid(in_valid), .in(in_ch),
      .out(b_out), .err(b_err), .depth(b_dep), .err_pos(b_pos)
   );

   expr_stream_checker #(
      .MAX_DIGITS(4), .MAX_DEPTH(7), .EN_SUB(1'b1), .EN_DIV(1'b0), .EN_PAREN(1'b0), .POS_W(16)
   ) u_c (
      .clk(clk), .clr_n(clr_n), .restart(restart), .in_valid(in_valid), .in(in_ch),
      .out(c_out), .err(c_err), .depth(c_dep), .err_pos(c_pos)
   );

   int p_maxd   [3] = '{4, 2, 4};
   int p_maxdep [3] = '{7, 3, 7};
   bit p_sub    [3] = '{1'b1, 1'b0, 1'b1};
   bit p_div    [3] = '{1'b0, 1'b1, 1'b0};
   bit p_par    [3] = '{1'b1, 1'b1, 1'b0};
   int p_psat   [3] = '{65535, 7, 65535};

   typedef struct packed {
      logic [2:0]       o;
      logic [2:0]       e;
      logic [2:0][15:0] d;
      logic [2:0][15:0] p;
   } exp_t;

   exp_t       sb[$];
   logic [7:0] str[$];   // characters accepted since the last restart/clear
   int checks = 0;
   int failures = 0;

   task automatic check(input string nm, input int act, input int exp_v);
      checks++;
      if (act != exp_v) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp_v);
      end
   endtask

   // Reference: adjacency rules of the grammar applied over the whole prefix.
   // prev: 0 start, 1 digit, 2 operator, 3 '(', 4 ')'
   function automatic void model(input int k, output int bad, output int dep, output bit done);
      int run, prev;
      logic [7:0] c;
      bit d, o, l, r, ok;
      bad = -1; dep = 0; run = 0; prev = 0;
      for (int i = 0; i < str.size(); i++) begin
         c = str[i];
         d = (c >= "0") && (c <= "9");
         o = (c == "+") || (c == "*") || (p_sub[k] && c == "-") || (p_div[k] && c == "/");
         l = p_par[k] && (c == "(");
         r = p_par[k] && (c == ")");
         if (d)      ok = (prev != 4) && (prev != 1 || run < p_maxd[k]);
         else if (o) ok = (prev == 1) || (prev == 4);
         else if (l) ok = (prev == 0 || prev == 2 || prev == 3) && (dep < p_maxdep[k]);
         else if (r) ok = (prev == 1 || prev == 4) && (dep > 0);
         else        ok = 1'b0;
         if (!ok) begin
            bad = i;
            break;
         end
         if (l) dep++;
         if (r) dep--;
         run  = d ? ((prev == 1) ? run + 1 : 1) : 0;
         prev = d ? 1 : o ? 2 : l ? 3 : 4;
      end
      done = (bad < 0) && (prev == 1 || prev == 4) && (dep == 0);
   endfunction

   task automatic step(input bit rs, input bit v, input logic [7:0] ch);
      exp_t x;
      int bad, dep;
      bit done;
      @(negedge clk);
      restart  = rs;
      in_valid = v;
      in_ch    = ch;
      if (rs) str.delete();
      if (v)  str.push_back(ch);
      for (int k = 0; k < 3; k++) begin
         model(k, bad, dep, done);
         x.o[k] = done;
         x.e[k] = (bad >= 0);
         x.d[k] = 16'(dep);
         x.p[k] = (bad < 0) ? 16'd0 : (bad > p_psat[k]) ? 16'(p_psat[k]) : 16'(bad);
      end
      sb.push_back(x);
   endtask

   task automatic send(input string s);
      logic [7:0] ch;
      for (int i = 0; i < s.len(); i++) begin
         ch = s[i];
         step(1'b0, 1'b1, ch);
      end
   endtask

   task automatic new_expr();
      step(1'b1, 1'b0, 8'h00);
   endtask

   // Land just after the edge that sampled the most recent step.
   task automatic settle();
      @(posedge clk);
      #2;
   endtask

   // Monitor: every edge that follows a step is compared against its record.
   initial begin
      exp_t x;
      forever begin
         @(posedge clk);
         #1;
         if (sb.size() > 0) begin
            x = sb.pop_front();
            check("A out", int'(a_out), int'(x.o[0]));
            check("A err", int'(a_err), int'(x.e[0]));
            check("A depth", int'(a_dep), int'(x.d[0]));
            check("A err_pos", int'(a_pos), int'(x.p[0]));
            check("B out", int'(b_out), int'(x.o[1]));
            check("B err", int'(b_err), int'(x.e[1]));
            check("B depth", int'(b_dep), int'(x.d[1]));
            check("B err_pos", int'(b_pos), int'(x.p[1]));
            check("C out", int'(c_out), int'(x.o[2]));
            check("C err", int'(c_err), int'(x.e[2]));
            check("C depth", int'(c_dep), int'(x.d[2]));
            check("C err_pos", int'(c_pos), int'(x.p[2]));
         end
      end
   end

   function automatic logic [7:0] rand_char();
      logic [7:0] pool;
      int r;
      pool = "+-*/";
      r = $urandom_range(0, 15);
      if (r <= 5)       return 8'("0" + $urandom_range(0, 9));
      else if (r == 6)  return "+";
      else if (r == 7)  return "-";
      else if (r == 8)  return "*";
      else if (r == 9)  return "/";
      else if (r <= 11) return "(";
      else if (r <= 13) return ")";
      else if (r == 14) return " ";
      else              return 8'($urandom_range(0, 255)) ^ (pool & 8'h00);
   endfunction

   initial begin
      int wait_cnt;
      #1;
      check("reset A out", int'(a_out), 0);
      check("reset A err", int'(a_err), 0);
      check("reset A depth", int'(a_dep), 0);
      check("reset A err_pos", int'(a_pos), 0);
      check("reset B err", int'(b_err), 0);
      check("reset C out", int'(c_out), 0);
      @(negedge clk);
      clr_n = 1'b1;

      send("12+3");
      new_expr();
      send("(1+2)*3");
      new_expr();
      send("12345");
      settle();
      check("12345 A err", int'(a_err), 1);
      check("12345 A err_pos", int'(a_pos), 4);
      check("12345 A out", int'(a_out), 0);
      step(1'b1, 1'b1, "7");
      settle();
      check("restart7 A out", int'(a_out), 1);
      check("restart7 A err", int'(a_err), 0);
      check("restart7 A err_pos", int'(a_pos), 0);

      new_expr();
      send("((((1");
      settle();
      check("deep B depth", int'(b_dep), 3);
      check("deep B err_pos", int'(b_pos), 3);

      new_expr();
      send("8/2");
      settle();
      check("div A err_pos", int'(a_pos), 1);
      check("div B out", int'(b_out), 1);
      check("div B err", int'(b_err), 0);

      new_expr();
      send("1+2+3+4++");
      settle();
      check("sat A err_pos", int'(a_pos), 8);
      check("sat B err_pos", int'(b_pos), 7);

      new_expr();
      send("(1");
      settle();
      check("noparen C err_pos", int'(c_pos), 0);
      check("noparen C err", int'(c_err), 1);

      new_expr();
      send("1");
      repeat (3) step(1'b0, 1'b0, 8'h00);
      send("+");
      repeat (3) step(1'b0, 1'b0, 8'h00);

      new_expr();
      send("(9");
      settle();
      #1;
      clr_n = 1'b0;
      #1;
      str.delete();
      check("clr A out", int'(a_out), 0);
      check("clr A err", int'(a_err), 0);
      check("clr A depth", int'(a_dep), 0);
      clr_n = 1'b1;
      send("5");
      settle();
      check("after clr A out", int'(a_out), 1);

      for (int n = 0; n < 2500; n++) begin
         step(($urandom_range(0, 24) == 0), ($urandom_range(0, 3) != 0), rand_char());
      end
      step(1'b0, 1'b0, 8'h00);

      wait_cnt = 0;
      while (sb.size() > 0 && wait_cnt < 20) begin
         @(posedge clk);
         #2;
         wait_cnt++;
      end
      check("scoreboard drained", sb.size(), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
